// File: rtl/led_pkg.sv
// Shared LED constants and types for the rotator top and the fader output stage.
package led_pkg;

  localparam int CHANNELS_DEF   = 4;
  localparam int BRIGHT_W_DEF   = 8;
  localparam int DECAY_DIV_DEF  = 64;
  localparam int DECAY_STEP_DEF = 16;

  typedef logic [BRIGHT_W_DEF-1:0] bright_t;

  localparam bright_t BRIGHT_MAX = '1;

endpackage

// File: rtl/led_fader_if.sv
// Pattern-in / PWM-out bundle between the LED rotator (master) and the fader (slave).
interface led_fader_if
  import led_pkg::*;
#(
  parameter int CHANNELS = CHANNELS_DEF
);

  logic                enable;
  logic [CHANNELS-1:0] pattern_in;
  logic [CHANNELS-1:0] led_out;
  logic                pwm_wrap;

  modport master (
    output enable,
    output pattern_in,
    input  led_out,
    input  pwm_wrap
  );

  modport slave (
    input  enable,
    input  pattern_in,
    output led_out,
    output pwm_wrap
  );

endinterface

// File: rtl/led_fader_channel.sv
// One fader channel: brightness with saturating decay, period-aligned duty shadow, PWM compare.
// Define LED_FADER_GAMMA_EN to map brightness through a squared (perceptual) curve.
module led_fader_channel #(
  parameter int BRIGHT_W   = 8,
  parameter int DECAY_STEP = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                set,
  input  logic [BRIGHT_W-1:0] pwm_cnt,
  input  logic                load,
  input  logic                decay,
  output logic                led
);

  localparam logic [BRIGHT_W-1:0] MAX  = '1;
  localparam logic [BRIGHT_W-1:0] STEP = BRIGHT_W'(DECAY_STEP);

  logic [BRIGHT_W-1:0] b_reg;
  logic [BRIGHT_W-1:0] b_next;
  logic [BRIGHT_W-1:0] d_reg;
  logic [BRIGHT_W-1:0] duty_f;
  logic                led_next;

`ifdef LED_FADER_GAMMA_EN
  function automatic logic [BRIGHT_W-1:0] gamma(input logic [BRIGHT_W-1:0] b);
    logic [2*BRIGHT_W-1:0] sq;
    sq = {{BRIGHT_W{1'b0}}, b} * {{BRIGHT_W{1'b0}}, b};
    return BRIGHT_W'(sq >> BRIGHT_W);
  endfunction

  // Full brightness must stay fully on, which the plain square would miss by one step.
  assign duty_f = (b_reg == MAX) ? MAX : gamma(b_reg);
`else
  assign duty_f = b_reg;
`endif

  always_comb begin
    b_next = b_reg;
    if (set) begin
      b_next = MAX;
    end else if (decay) begin
      b_next = (b_reg > STEP) ? (b_reg - STEP) : '0;
    end
  end

  assign led_next = (d_reg == MAX) | (pwm_cnt < d_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_reg <= '0;
      d_reg <= '0;
      led   <= 1'b0;
    end else if (enable) begin
      b_reg <= b_next;
      if (load) begin
        d_reg <= duty_f;
      end
      led <= led_next;
    end else begin
      led <= 1'b0;
    end
  end

endmodule

// File: rtl/led_fader.sv
// LED afterglow output stage: shared PWM counter and decay prescaler driving per-channel faders.
// Optional perceptual curve: define LED_FADER_GAMMA_EN.
module led_fader
  import led_pkg::*;
#(
  parameter int CHANNELS   = CHANNELS_DEF,
  parameter int BRIGHT_W   = BRIGHT_W_DEF,
  parameter int DECAY_DIV  = DECAY_DIV_DEF,
  parameter int DECAY_STEP = DECAY_STEP_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  led_fader_if.slave bus
);

  localparam int PRESC_W = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;

  localparam logic [BRIGHT_W-1:0] CNT_MAX    = '1;
  localparam logic [BRIGHT_W-1:0] CNT_ONE    = BRIGHT_W'(1);
  localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(DECAY_DIV - 1);
  localparam logic [PRESC_W-1:0]  PRESC_ONE  = PRESC_W'(1);

  logic [BRIGHT_W-1:0] pwm_cnt_reg;
  logic [PRESC_W-1:0]  presc_reg;
  logic [CHANNELS-1:0] pat_q_reg;
  logic                pwm_wrap_reg;
  logic [CHANNELS-1:0] led_bits;

  logic period_end;
  logic decay_tick;

  // Last cycle of a PWM period: duty shadows reload here, and decay may fire.
  assign period_end = bus.enable & (pwm_cnt_reg == CNT_MAX);
  assign decay_tick = period_end & (presc_reg == PRESC_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_reg  <= '0;
      presc_reg    <= '0;
      pat_q_reg    <= '0;
      pwm_wrap_reg <= 1'b0;
    end else begin
      pwm_wrap_reg <= period_end;
      if (bus.enable) begin
        pwm_cnt_reg <= pwm_cnt_reg + CNT_ONE;
        pat_q_reg   <= bus.pattern_in;
        if (period_end) begin
          presc_reg <= (presc_reg == PRESC_LAST) ? '0 : (presc_reg + PRESC_ONE);
        end
      end
    end
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    led_fader_channel #(
      .BRIGHT_W   (BRIGHT_W),
      .DECAY_STEP (DECAY_STEP)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .enable  (bus.enable),
      .set     (pat_q_reg[gi]),
      .pwm_cnt (pwm_cnt_reg),
      .load    (period_end),
      .decay   (decay_tick),
      .led     (led_bits[gi])
    );
  end

  assign bus.led_out  = led_bits;
  assign bus.pwm_wrap = pwm_wrap_reg;

endmodule
